// File: rtl/y_alu_pkg.sv
// -----------------------------------------------------------------------------
// y_alu_pkg
// Purpose : shared constants for the y_alu execute-stage ALU.
//           - ALU_W : default operand/result width.
//           - OP_*  : 3-bit operation select encodings.
//           - uses_subtract() : true for ops that drive the shared adder in
//             subtract mode (SUB and SLT).
// Ports   : none (package).
// Config  : none here; the top honours macro Y_ALU_OVF_EN.
// -----------------------------------------------------------------------------
package y_alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // SLT is derived from a-b, so it shares the subtract path with SUB.
  function automatic logic uses_subtract(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/y_alu_addsub.sv
// -----------------------------------------------------------------------------
// y_alu_addsub
// Purpose : W-bit two's-complement adder with invert-b / carry-in control.
//           i_sub=0 : o_sum = i_a + i_b
//           i_sub=1 : o_sum = i_a + ~i_b + 1  (= i_a - i_b)
//           Carry-out is not produced; results wrap modulo 2^W.
// Ports   : i_a   [W-1:0] operand A
//           i_b   [W-1:0] operand B
//           i_sub         1 selects subtract
//           o_sum [W-1:0] wrapped sum/difference
//           o_ovf         signed overflow of the operation performed
// -----------------------------------------------------------------------------
module y_alu_addsub
  import y_alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  logic [W-1:0] w_b_eff;

  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign o_sum   = i_a + w_b_eff + {{(W-1){1'b0}}, i_sub};

  // Overflow when the two addends (after the conditional inversion) share a
  // sign and the result does not. For subtract this reduces to "a and b
  // differ in sign and the result sign differs from a".
  assign o_ovf = (i_a[W-1] == w_b_eff[W-1]) && (o_sum[W-1] != i_a[W-1]);

endmodule

// File: rtl/y_alu.sv
// -----------------------------------------------------------------------------
// y_alu
// Purpose : registered W-bit integer ALU (AND, OR, ADD, SUB, signed SLT) with
//           zero flag, one-cycle latency, throughput of one op per cycle.
// Ports   : clk            clock, rising edge
//           rst_n          asynchronous active-low reset
//           in_vld         a/b/op valid this cycle
//           a, b  [W-1:0]  two's-complement operands
//           op    [2:0]    operation select (see y_alu_pkg OP_*)
//           z     [W-1:0]  registered result
//           ex             registered zero flag (z == 0)
//           ovf            (only with Y_ALU_OVF_EN) registered signed
//                          overflow for ADD/SUB, 0 otherwise
//           out_vld        z/ex hold a fresh result
// Config  : define Y_ALU_OVF_EN to expose the ovf output.
// -----------------------------------------------------------------------------
module y_alu
  import y_alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] z,
  output logic         ex,
`ifdef Y_ALU_OVF_EN
  output logic         ovf,
`endif
  output logic         out_vld
);

  logic [W-1:0] w_sum;
  logic         w_ovf;
  logic         w_sub;
  logic         w_slt;
  logic [W-1:0] w_res;
  logic         w_zero;

  logic [W-1:0] r_z;
  logic         r_ex;
  logic         r_out_vld;

  assign w_sub = uses_subtract(op);

  y_alu_addsub #(
    .W (W)
  ) u_addsub (
    .i_a   (a),
    .i_b   (b),
    .i_sub (w_sub),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // Sign of (a-b) corrected by overflow gives the true signed comparison,
  // including the most-negative / most-positive extremes.
  assign w_slt = w_sum[W-1] ^ w_ovf;

  always_comb begin
    w_res = '0;
    case (op)
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_ADD:  w_res = w_sum;
      OP_SUB:  w_res = w_sum;
      OP_SLT:  w_res = {{(W-1){1'b0}}, w_slt};
      default: w_res = '0;
    endcase
  end

  assign w_zero = (w_res == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z       <= '0;
      r_ex      <= 1'b1;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= in_vld;
      if (in_vld) begin
        r_z  <= w_res;
        r_ex <= w_zero;
      end
    end
  end

  assign z       = r_z;
  assign ex      = r_ex;
  assign out_vld = r_out_vld;

`ifdef Y_ALU_OVF_EN
  logic w_ovf_next;
  logic r_ovf;

  assign w_ovf_next = ((op == OP_ADD) || (op == OP_SUB)) ? w_ovf : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_vld) begin
      r_ovf <= w_ovf_next;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_y_alu.sv
// -----------------------------------------------------------------------------
// tb_y_alu
// Purpose : self-checking bench for y_alu (W=32). Directed vector table issued
//           back-to-back, hold behaviour with in_vld=0, random operands per
//           opcode against a behavioural model, and asynchronous reset
//           mid-stream. Honours Y_ALU_OVF_EN for the ovf port.
// -----------------------------------------------------------------------------
module tb_y_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic [W-1:0]  z;
  logic          ex;
  logic          out_vld;
`ifdef Y_ALU_OVF_EN
  logic          ovf;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  y_alu #(
    .W (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .a       (a),
    .b       (b),
    .op      (op),
    .z       (z),
    .ex      (ex),
`ifdef Y_ALU_OVF_EN
    .ovf     (ovf),
`endif
    .out_vld (out_vld)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        ex;
    logic        ovf;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb);
    case (mop)
      3'b000:  return ma & mb;
      3'b001:  return ma | mb;
      3'b010:  return ma + mb;
      3'b110:  return ma - mb;
      3'b111:  return ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  rops[5];
    logic [31:0] exp_z;

    rops[0] = 3'b000; rops[1] = 3'b001; rops[2] = 3'b010;
    rops[3] = 3'b110; rops[4] = 3'b111;

    //            name         op      a             b             z             ex    ovf
    vecs[0]  = '{"and",       3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0};
    vecs[1]  = '{"or",        3'b001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0};
    vecs[2]  = '{"add_ovf",   3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[3]  = '{"add_wrap",  3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[4]  = '{"sub_eq",    3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{"sub_neg",   3'b110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[6]  = '{"slt_m1_1",  3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[7]  = '{"slt_1_m1",  3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
    vecs[8]  = '{"slt_min",   3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
    vecs[9]  = '{"slt_max",   3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{"undef011",  3'b011, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1, 1'b0};
    vecs[11] = '{"undef100",  3'b100, 32'hFFFFFFFF, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{"undef101",  3'b101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{"sub_ovf",   3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[14] = '{"add_minmin",3'b010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    vecs[15] = '{"sub_0_min", 3'b110, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1};

    rst_n  = 1'b0;
    in_vld = 1'b0;
    a      = '0;
    b      = '0;
    op     = '0;

    // Reset values
    repeat (2) step();
    check("rst_z", z, 32'h0);
    check("rst_ex", {31'd0, ex}, 32'd1);
    check("rst_vld", {31'd0, out_vld}, 32'd0);
`ifdef Y_ALU_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;

    // Directed table, issued back-to-back
    for (int i = 0; i < 16; i++) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; in_vld = 1'b1;
      step();
      $display("vec %0d %s op=%b a=%h b=%h -> z=%h ex=%b vld=%b",
               i, vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, z, ex, out_vld);
      check({vecs[i].name, "_z"}, z, vecs[i].z);
      check({vecs[i].name, "_ex"}, {31'd0, ex}, {31'd0, vecs[i].ex});
      check({vecs[i].name, "_vld"}, {31'd0, out_vld}, 32'd1);
`ifdef Y_ALU_OVF_EN
      check({vecs[i].name, "_ovf"}, {31'd0, ovf}, {31'd0, vecs[i].ovf});
`endif
    end

    // in_vld=0 holds z/ex (last result 0x80000000) and drops out_vld
    in_vld = 1'b0; op = 3'b110; a = 32'd5; b = 32'd5;
    step();
    $display("hold in_vld=0 -> z=%h ex=%b vld=%b", z, ex, out_vld);
    check("hold_z", z, 32'h80000000);
    check("hold_ex", {31'd0, ex}, 32'd0);
    check("hold_vld", {31'd0, out_vld}, 32'd0);
`ifdef Y_ALU_OVF_EN
    check("hold_ovf", {31'd0, ovf}, 32'd1);
`endif

    // Random operands, 10 per opcode, back-to-back
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 10; j++) begin
        op = rops[k]; a = $urandom; b = $urandom; in_vld = 1'b1;
        if (j == 0) a = b;  // exercise equality / zero results
        exp_z = model(op, a, b);
        step();
        $display("rnd op=%b a=%h b=%h -> z=%h ex=%b", op, a, b, z, ex);
        check("rnd_z", z, exp_z);
        check("rnd_ex", {31'd0, ex}, {31'd0, (exp_z == 32'd0)});
        check("rnd_vld", {31'd0, out_vld}, 32'd1);
      end
    end

    // Mid-stream asynchronous reset
    op = 3'b001; a = 32'd1; b = 32'd2; in_vld = 1'b1;
    step();
    $display("pre-reset op=001 -> z=%h", z);
    check("prerst_z", z, 32'd3);
    op = 3'b010; a = 32'd7; b = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-cycle -> z=%h ex=%b vld=%b", z, ex, out_vld);
    check("arst_z", z, 32'd0);
    check("arst_ex", {31'd0, ex}, 32'd1);
    check("arst_vld", {31'd0, out_vld}, 32'd0);
    step();
    check("arst_hold_z", z, 32'd0);
    check("arst_hold_vld", {31'd0, out_vld}, 32'd0);
    rst_n = 1'b1; in_vld = 1'b0;
    step();
    check("post_rst_vld", {31'd0, out_vld}, 32'd0);
    check("post_rst_ex", {31'd0, ex}, 32'd1);
    op = 3'b110; a = 32'd9; b = 32'd4; in_vld = 1'b1;
    step();
    $display("post-reset op=110 a=9 b=4 -> z=%h", z);
    check("post_rst_sub", z, 32'd5);
    check("post_rst_vld1", {31'd0, out_vld}, 32'd1);
    in_vld = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
